// File: rtl/call_stack_pkg.sv
// Shared definitions for the call_stack search-frame stack.
// Holds the FSM state type, the position codes, the frame layout and
// the default geometry used by call_stack and stack_ram.
package call_stack_pkg;

    localparam int DEPTH_DEF   = 16;
    localparam int FRAME_W_DEF = 37;
    localparam int POS_W       = 5;

    // Position codes carried in the top 5 bits of every frame.
    localparam logic [POS_W-1:0] NONE        = 5'd0;
    localparam logic [POS_W-1:0] STOP_1      = 5'd1;
    localparam logic [POS_W-1:0] STOP_2      = 5'd2;
    localparam logic [POS_W-1:0] A_MATCH     = 5'd3;
    localparam logic [POS_W-1:0] A_MISMATCH  = 5'd4;
    localparam logic [POS_W-1:0] A_INSERTION = 5'd5;
    localparam logic [POS_W-1:0] A_DELETION  = 5'd6;
    localparam logic [POS_W-1:0] T_SNP       = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    // position[36:32], i[31:24], z[23:16], k[15:8], l[7:0]
    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic [7:0]       i;
        logic [7:0]       z;
        logic [7:0]       k;
        logic [7:0]       l;
    } frame_t;

endpackage

// File: rtl/stack_ram.sv
// Frame storage for call_stack: DEPTH x FRAME_W, synchronous write,
// asynchronous read. Two write ports: one rewrites only the position
// field of a slot (top update), the other writes a whole frame (push).
// Ports:
//   clk                         write clock
//   upd_we, upd_addr, upd_pos   position rewrite port
//   push_we, push_addr, push_data  full-frame write port
//   rd_addr, rd_data            asynchronous read port
module stack_ram
    import call_stack_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               upd_we,
    input  logic [AW-1:0]      upd_addr,
    input  logic [POS_W-1:0]   upd_pos,
    input  logic               push_we,
    input  logic [AW-1:0]      push_addr,
    input  logic [FRAME_W-1:0] push_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [FRAME_W-1:0] rd_data
);

    logic [FRAME_W-1:0] mem [DEPTH];

    // The two ports never target the same slot in one cycle: the update
    // port addresses the current top, the push port the slot above it.
    always_ff @(posedge clk) begin
        if (upd_we) begin
            mem[upd_addr][FRAME_W-1 -: POS_W] <= upd_pos;
        end
        if (push_we) begin
            mem[push_addr] <= push_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/call_stack.sv
// Search-frame call stack. Holds the frames of a depth-first search,
// presents the top frame to an executor and applies its verdict
// (pop, pop-with-hit, position rewrite, position rewrite plus push).
//
// state  | meaning
// IDLE   | no search loaded, waiting for start
// RUN    | top frame presented, executor verdicts accepted
// DONE   | last frame popped, done held until start
// ERROR  | push attempted while full, overflow held until start
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start, i/z/k/l_start               load root frame
//   ex_valid, en_new_position, new_position, new_call,
//   i/z/k/l_new, over_1, over_2, finish   executor verdict
//   frame_valid, position_out, i/z/k/l_out  top frame
//   hit_valid, hit_k, hit_l            hit report (one-cycle pulse)
//   depth, done, overflow              status
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] i_start,
    input  logic [7:0] z_start,
    input  logic [7:0] k_start,
    input  logic [7:0] l_start,
    input  logic       ex_valid,
    input  logic       en_new_position,
    input  logic [4:0] new_position,
    input  logic       new_call,
    input  logic [7:0] i_new,
    input  logic [7:0] z_new,
    input  logic [7:0] k_new,
    input  logic [7:0] l_new,
    input  logic       over_1,
    input  logic       over_2,
    input  logic       finish,
    output logic       frame_valid,
    output logic [4:0] position_out,
    output logic [7:0] i_out,
    output logic [7:0] z_out,
    output logic [7:0] k_out,
    output logic [7:0] l_out,
    output logic       hit_valid,
    output logic [7:0] hit_k,
    output logic [7:0] hit_l,
    output logic [4:0] depth,
    output logic       done,
    output logic       overflow
);

    localparam int         AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL = 5'(DEPTH);

    state_e             state;
    logic [4:0]         depth_r;
    logic [FRAME_W-1:0] rd_data;
    logic [FRAME_W-1:0] push_data;
    frame_t             top_f;
    frame_t             load_f;
    frame_t             child_f;
    logic               accept;
    logic               ev_pop;
    logic               ev_upd;
    logic               ev_push;
    logic               full;
    logic               load;

    // frame_valid is high exactly in RUN, so it doubles as the accept gate.
    assign accept  = frame_valid & ex_valid;
    assign ev_pop  = accept & (finish | over_2 | over_1);
    assign ev_upd  = accept & ~ev_pop & en_new_position;
    assign full    = (depth_r == FULL);
    assign ev_push = ev_upd & new_call & ~full;
    assign load    = start & (state != ST_RUN);

    assign load_f  = '{pos: NONE, i: i_start, z: z_start, k: k_start, l: l_start};
    assign child_f = '{pos: NONE, i: i_new, z: z_new, k: k_new, l: l_new};
    assign push_data = load ? load_f : child_f;

    stack_ram #(
        .DEPTH   (DEPTH),
        .FRAME_W (FRAME_W),
        .AW      (AW)
    ) u_ram (
        .clk       (clk),
        .upd_we    (ev_upd),
        .upd_addr  (AW'(depth_r - 5'd1)),
        .upd_pos   (new_position),
        .push_we   (load | ev_push),
        .push_addr (load ? '0 : AW'(depth_r)),
        .push_data (push_data),
        .rd_addr   (AW'(depth_r - 5'd1)),
        .rd_data   (rd_data)
    );

    // Storage is never reset, so mask the read while the stack is empty.
    assign top_f = (depth_r != 5'd0) ? frame_t'(rd_data) : '0;

    assign position_out = top_f.pos;
    assign i_out        = top_f.i;
    assign z_out        = top_f.z;
    assign k_out        = top_f.k;
    assign l_out        = top_f.l;
    assign depth        = depth_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            depth_r     <= 5'd0;
            frame_valid <= 1'b0;
            hit_valid   <= 1'b0;
            hit_k       <= 8'd0;
            hit_l       <= 8'd0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            hit_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state       <= ST_RUN;
                        depth_r     <= 5'd1;
                        frame_valid <= 1'b1;
                        done        <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (ev_pop) begin
                        depth_r <= depth_r - 5'd1;
                        // finish outranks over_2: a finishing frame reports no hit.
                        if (over_2 && !finish) begin
                            hit_valid <= 1'b1;
                            hit_k     <= top_f.k;
                            hit_l     <= top_f.l;
                        end
                        if (depth_r == 5'd1) begin
                            state       <= ST_DONE;
                            done        <= 1'b1;
                            frame_valid <= 1'b0;
                        end
                    end else if (ev_upd && new_call) begin
                        if (full) begin
                            state       <= ST_ERROR;
                            overflow    <= 1'b1;
                            frame_valid <= 1'b0;
                        end else begin
                            depth_r <= depth_r + 5'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios followed by
// random executor traffic compared against a queue-based stack model.
module tb_call_stack;
    import call_stack_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] i_start, z_start, k_start, l_start;
    logic       ex_valid, en_new_position, new_call;
    logic [4:0] new_position;
    logic [7:0] i_new, z_new, k_new, l_new;
    logic       over_1, over_2, finish;
    logic       frame_valid, hit_valid, done, overflow;
    logic [4:0] position_out, depth;
    logic [7:0] i_out, z_out, k_out, l_out, hit_k, hit_l;

    call_stack #(.DEPTH(DEPTH), .FRAME_W(37)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .i_start(i_start), .z_start(z_start), .k_start(k_start), .l_start(l_start),
        .ex_valid(ex_valid), .en_new_position(en_new_position),
        .new_position(new_position), .new_call(new_call),
        .i_new(i_new), .z_new(z_new), .k_new(k_new), .l_new(l_new),
        .over_1(over_1), .over_2(over_2), .finish(finish),
        .frame_valid(frame_valid), .position_out(position_out),
        .i_out(i_out), .z_out(z_out), .k_out(k_out), .l_out(l_out),
        .hit_valid(hit_valid), .hit_k(hit_k), .hit_l(hit_l),
        .depth(depth), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] pos;
        logic [7:0] i, z, k, l;
    } mframe_t;

    mframe_t    q[$];
    bit         m_run, m_done, m_ovf, m_hit;
    logic [7:0] m_hk, m_hl;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 0; m_done = 0; m_ovf = 0; m_hit = 0;
        m_hk = 8'd0; m_hl = 8'd0;
    endtask

    // Next-cycle behaviour of the stack given the inputs currently driven.
    task automatic model_step();
        mframe_t f;
        m_hit = 0;
        if (start && !m_run) begin
            q.delete();
            f.pos = NONE; f.i = i_start; f.z = z_start; f.k = k_start; f.l = l_start;
            q.push_back(f);
            m_run = 1; m_done = 0; m_ovf = 0;
        end else if (m_run && ex_valid) begin
            if (finish || over_1 || over_2) begin
                if (over_2 && !finish) begin
                    m_hit = 1; m_hk = q[$].k; m_hl = q[$].l;
                end
                void'(q.pop_back());
                if (q.size() == 0) begin
                    m_run = 0; m_done = 1;
                end
            end else if (en_new_position) begin
                q[$].pos = new_position;
                if (new_call) begin
                    if (q.size() == DEPTH) begin
                        m_ovf = 1; m_run = 0;
                    end else begin
                        f.pos = NONE; f.i = i_new; f.z = z_new; f.k = k_new; f.l = l_new;
                        q.push_back(f);
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        mframe_t t;
        t = '{default: '0};
        if (q.size() > 0) t = q[$];
        check({ctx, "/frame_valid"}, frame_valid, m_run);
        check({ctx, "/depth"}, depth, q.size());
        check({ctx, "/position"}, position_out, t.pos);
        check({ctx, "/i"}, i_out, t.i);
        check({ctx, "/z"}, z_out, t.z);
        check({ctx, "/k"}, k_out, t.k);
        check({ctx, "/l"}, l_out, t.l);
        check({ctx, "/hit_valid"}, hit_valid, m_hit);
        check({ctx, "/hit_k"}, hit_k, m_hk);
        check({ctx, "/hit_l"}, hit_l, m_hl);
        check({ctx, "/done"}, done, m_done);
        check({ctx, "/overflow"}, overflow, m_ovf);
    endtask

    task automatic clear_inputs();
        start = 0; ex_valid = 0; en_new_position = 0; new_call = 0;
        over_1 = 0; over_2 = 0; finish = 0; new_position = 5'd0;
        i_start = 0; z_start = 0; k_start = 0; l_start = 0;
        i_new = 0; z_new = 0; k_new = 0; l_new = 0;
    endtask

    // Called at a falling edge with inputs set: advance one cycle and check.
    task automatic step(input string ctx);
        model_step();
        @(negedge clk);
        check_all(ctx);
        clear_inputs();
    endtask

    task automatic push_child(input logic [4:0] p, input logic [7:0] i, z, k, l);
        ex_valid = 1; en_new_position = 1; new_call = 1; new_position = p;
        i_new = i; z_new = z; k_new = k; l_new = l;
    endtask

    task automatic randomize_inputs();
        start    = ($urandom_range(0, 99) < (m_run ? 5 : 30));
        i_start  = 8'($urandom); z_start = 8'($urandom);
        k_start  = 8'($urandom); l_start = 8'($urandom);
        ex_valid = ($urandom_range(0, 99) < 70);
        finish   = ($urandom_range(0, 99) < 8);
        over_1   = ($urandom_range(0, 99) < 8);
        over_2   = ($urandom_range(0, 99) < 10);
        en_new_position = ($urandom_range(0, 99) < 60);
        new_call = en_new_position && ($urandom_range(0, 99) < 55);
        new_position = 5'($urandom_range(0, 7));
        i_new = 8'($urandom); z_new = 8'($urandom);
        k_new = 8'($urandom); l_new = 8'($urandom);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1;
        @(negedge clk);
        check_all("idle");

        // root load
        start = 1; i_start = 8'd3; z_start = 8'd1; k_start = 8'd0; l_start = 8'd20;
        step("root");
        check("root_fv", frame_valid, 1'b1);
        check("root_depth", depth, 5'd1);
        check("root_pos", position_out, NONE);
        check("root_i", i_out, 8'd3);

        // call: position rewrite plus push
        push_child(A_INSERTION, 8'd3, 8'd0, 8'd5, 8'd9);
        step("call");
        check("call_depth", depth, 5'd2);
        check("call_pos", position_out, NONE);
        check("call_k", k_out, 8'd5);
        check("call_l", l_out, 8'd9);

        // hit: pop child, report its interval, parent shows rewritten position
        ex_valid = 1; over_2 = 1;
        step("hit");
        check("hit_valid", hit_valid, 1'b1);
        check("hit_k", hit_k, 8'd5);
        check("hit_l", hit_l, 8'd9);
        check("hit_depth", depth, 5'd1);
        check("hit_parent_pos", position_out, A_INSERTION);
        step("hit_after");
        check("hit_pulse_end", hit_valid, 1'b0);

        // finish outranks position rewrite at depth 1
        ex_valid = 1; finish = 1; en_new_position = 1; new_position = T_SNP;
        step("finish");
        check("fin_depth", depth, 5'd0);
        check("fin_done", done, 1'b1);
        check("fin_fv", frame_valid, 1'b0);

        // ex_valid in DONE is ignored
        push_child(A_MATCH, 8'd1, 8'd1, 8'd1, 8'd1);
        step("done_ignore");
        check("done_hold_depth", depth, 5'd0);

        // overflow: 16 pushes from depth 1
        start = 1; i_start = 8'hF0; z_start = 8'h80; k_start = 8'd1; l_start = 8'd2;
        step("reload");
        check("reload_done", done, 1'b0);
        for (int n = 0; n < 16; n++) begin
            push_child(5'(n % 8), 8'(n), 8'(n + 1), 8'(n + 2), 8'(n + 3));
            step("ovf_push");
        end
        check("ovf_flag", overflow, 1'b1);
        check("ovf_depth", depth, 5'd16);
        check("ovf_fv", frame_valid, 1'b0);
        start = 1; i_start = 8'd7; z_start = 8'd8; k_start = 8'd9; l_start = 8'd10;
        step("ovf_clear");
        check("ovf_cleared", overflow, 1'b0);
        check("ovf_clear_depth", depth, 5'd1);

        // start while running is ignored
        start = 1; i_start = 8'd99;
        step("start_in_run");
        check("run_start_i", i_out, 8'd7);

        // asynchronous reset mid-run at depth 7
        for (int n = 0; n < 6; n++) begin
            push_child(A_MATCH, 8'(n), 8'(n), 8'(n), 8'(n));
            step("to_depth7");
        end
        check("pre_reset_depth", depth, 5'd7);
        ex_valid = 1; over_2 = 1;
        #2 rst_n = 0;
        #1;
        check("async_depth", depth, 5'd0);
        check("async_fv", frame_valid, 1'b0);
        clear_inputs();
        model_reset();
        @(negedge clk);
        check_all("in_reset");
        rst_n = 1;
        @(negedge clk);
        check_all("post_reset");

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 0;
                #1;
                check("rand_rst_depth", depth, 5'd0);
                model_reset();
                #1 rst_n = 1;
            end
            randomize_inputs();
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
